// File: rtl/srlatch_pkg.sv
// Purpose: shared FSM state, op encodings and defaults for the SR-latch bank controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package srlatch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_ACK   = 3'd4
    } state_t;

    localparam logic OP_SET = 1'b1;
    localparam logic OP_CLR = 1'b0;

    localparam int DEF_PULSE_CYCLES = 2;

endpackage

// File: rtl/rr_arb2.sv
// Purpose: 2-input round-robin arbiter; the requester not granted last wins a tie.
// Latency: grant is combinational from req; pointer moves on the edge where grant_en is high.
// Backpressure: none; pointer holds while grant_en is low, so unserved requests keep priority.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    // 0 favours requester 0 on a tie, 1 favours requester 1
    logic ptr_q;

    // Pick the winner: a lone request wins outright, a tie goes to the pointer
    always_comb begin
        gnt_id = 1'b0;
        gnt    = 2'b00;
        if (req == 2'b11) begin
            gnt_id = ptr_q;
        end else begin
            gnt_id = req[1];
        end
        if (req != 2'b00) begin
            gnt = gnt_id ? 2'b10 : 2'b01;
        end
    end

    // After a grant, hand tie priority to the other requester
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else if (grant_en && (req != 2'b00)) begin
            ptr_q <= ~gnt_id;
        end
    end

endmodule

// File: rtl/srlatch_bank_ctrl.sv
// Purpose: arbitrate two set/clear requesters and sequence s/r/c of a gated SR-latch bank.
// Latency: ack pulses PULSE_CYCLES+3 cycles after the grant edge; all outputs registered.
// Backpressure: requesters hold req until ack; no new grant while busy or during the ack cycle.
module srlatch_bank_ctrl
    import srlatch_pkg::*;
#(
    parameter int N_LATCH      = 4,
    parameter int ADDR_W       = 2,
    parameter int PULSE_CYCLES = DEF_PULSE_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0,
    input  logic               op0,
    input  logic [ADDR_W-1:0]  addr0,
    input  logic               req1,
    input  logic               op1,
    input  logic [ADDR_W-1:0]  addr1,
    output logic               ack0,
    output logic               ack1,
    output logic               err,
    output logic               busy,
    output logic [N_LATCH-1:0] latch_s,
    output logic [N_LATCH-1:0] latch_r,
    output logic [N_LATCH-1:0] latch_c
);

    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(N_LATCH);

    state_t              state_q;
    state_t              state_d;
    logic [3:0]          cnt_q;
    logic                id_q;
    logic                op_q;
    logic                oor_q;
    logic [ADDR_W-1:0]   addr_q;

    logic                grant_en;
    logic [1:0]          gnt;
    logic                gnt_id;
    logic                op_sel;
    logic [ADDR_W-1:0]   addr_sel;

    logic [N_LATCH-1:0]  sel;
    logic [N_LATCH-1:0]  s_d;
    logic [N_LATCH-1:0]  r_d;
    logic [N_LATCH-1:0]  c_d;
    logic                ack0_d;
    logic                ack1_d;
    logic                err_d;

    // The ack cycle is treated as part of the command: a requester still
    // holding req while it sees ack must not be granted a second time.
    assign grant_en = (state_q == ST_IDLE) && (req0 || req1) && !(ack0 || ack1);

    rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .req      ({req1, req0}),
        .grant_en (grant_en),
        .gnt      (gnt),
        .gnt_id   (gnt_id)
    );

    assign op_sel   = (gnt == 2'b10) ? op1   : op0;
    assign addr_sel = (gnt == 2'b10) ? addr1 : addr0;

    // State register, pulse counter and command capture at grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            id_q    <= 1'b0;
            op_q    <= OP_CLR;
            oor_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (grant_en) begin
                id_q   <= gnt_id;
                op_q   <= op_sel;
                addr_q <= addr_sel;
                oor_q  <= ({1'b0, addr_sel} >= ADDR_LIMIT);
            end
            if (state_q == ST_SETUP) begin
                cnt_q <= 4'(PULSE_CYCLES - 1);
            end else if ((state_q == ST_PULSE) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    // Next-state: fixed setup / pulse / hold / ack sequence per command
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (grant_en) state_d = ST_SETUP;
            ST_SETUP: state_d = ST_PULSE;
            ST_PULSE: if (cnt_q == 4'd0) state_d = ST_HOLD;
            ST_HOLD:  state_d = ST_ACK;
            ST_ACK:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode from the current state; registered below, so the latch
    // lines trail the state by one cycle and s/r bracket c on both sides.
    always_comb begin
        s_d    = '0;
        r_d    = '0;
        c_d    = '0;
        ack0_d = 1'b0;
        ack1_d = 1'b0;
        err_d  = 1'b0;
        for (int i = 0; i < N_LATCH; i++) begin
            sel[i] = !oor_q && (int'(addr_q) == i);
        end
        case (state_q)
            ST_SETUP, ST_HOLD: begin
                s_d = op_q ? sel : '0;
                r_d = op_q ? '0  : sel;
            end
            ST_PULSE: begin
                s_d = op_q ? sel : '0;
                r_d = op_q ? '0  : sel;
                c_d = sel;
            end
            ST_ACK: begin
                ack0_d = ~id_q;
                ack1_d = id_q;
                err_d  = oor_q;
            end
            default: ;
        endcase
    end

    // Output registers; reset clears every line asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            latch_s <= '0;
            latch_r <= '0;
            latch_c <= '0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            latch_s <= s_d;
            latch_r <= r_d;
            latch_c <= c_d;
            ack0    <= ack0_d;
            ack1    <= ack1_d;
            err     <= err_d;
            busy    <= (state_d != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_srlatch_bank_ctrl.sv
// Purpose: self-checking bench for srlatch_bank_ctrl with a queue of expected commands.
// Latency: expects latch lines at grant+1..P+2, c at grant+2..P+1, ack at grant+P+3.
// Backpressure: requesters hold req until ack, then drop it during the ack cycle.
module tb_srlatch_bank_ctrl;

    localparam int N  = 3;
    localparam int AW = 2;
    localparam int P  = 2;

    typedef struct {
        int         g;
        bit         id;
        bit         op;
        logic [1:0] addr;
        bit         err;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, op0, req1, op1;
    logic [AW-1:0] addr0, addr1;
    logic          ack0, ack1, err, busy;
    logic [N-1:0]  latch_s, latch_r, latch_c;

    exp_t          sb[$];
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            inv_bad = 0;
    logic [N-1:0]  q = '0;

    srlatch_bank_ctrl #(.N_LATCH(N), .ADDR_W(AW), .PULSE_CYCLES(P)) dut (
        .clk     (clk),
        .reset   (reset),
        .req0    (req0),
        .op0     (op0),
        .addr0   (addr0),
        .req1    (req1),
        .op1     (op1),
        .addr1   (addr1),
        .ack0    (ack0),
        .ack1    (ack1),
        .err     (err),
        .busy    (busy),
        .latch_s (latch_s),
        .latch_r (latch_r),
        .latch_c (latch_c)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Latch-bank model, invariants and scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        logic [N-1:0] es, er, ec;
        int k;
        exp_t h;
        for (int i = 0; i < N; i++) begin
            if (latch_c[i]) begin
                if (latch_s[i]) q[i] = 1'b1;
                else if (latch_r[i]) q[i] = 1'b0;
            end
        end
        if ((latch_s & latch_r) != '0 || $countones(latch_c) > 1 || (ack0 && ack1))
            inv_bad++;
        if (!reset) begin
            es = '0; er = '0; ec = '0; k = -1;
            if (sb.size() > 0) begin
                h = sb[0];
                k = cyc - h.g;
                if (!h.err && k >= 1 && k <= P + 2) begin
                    es[h.addr] = h.op;
                    er[h.addr] = !h.op;
                end
                if (!h.err && k >= 2 && k <= P + 1) ec[h.addr] = 1'b1;
            end
            chk("latch_s", 32'(latch_s), 32'(es));
            chk("latch_r", 32'(latch_r), 32'(er));
            chk("latch_c", 32'(latch_c), 32'(ec));
            if (sb.size() > 0 && k == P + 3) begin
                chk("ack0", 32'(ack0), 32'(!h.id));
                chk("ack1", 32'(ack1), 32'(h.id));
                chk("err",  32'(err),  32'(h.err));
                void'(sb.pop_front());
            end else if (ack0 || ack1) begin
                chk("unexpected_ack", 32'({ack1, ack0}), 32'd0);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic push(input int g, input bit id, input bit op, input logic [1:0] addr);
        exp_t e;
        e.g = g; e.id = id; e.op = op; e.addr = addr; e.err = (int'(addr) >= N);
        sb.push_back(e);
    endtask

    task automatic issue(input bit id, input bit op, input logic [1:0] addr);
        tick();
        if (id) begin req1 = 1'b1; op1 = op; addr1 = addr; end
        else    begin req0 = 1'b1; op0 = op; addr0 = addr; end
        push(cyc + 1, id, op, addr);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60; i++) begin
            tick();
            if (ack0) req0 = 1'b0;
            if (ack1) req1 = 1'b0;
            if (sb.size() == 0 && !req0 && !req1) break;
        end
        chk("drain", 32'(sb.size()), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req0 = 1'b0; op0 = 1'b0; addr0 = '0;
        req1 = 1'b0; op1 = 1'b0; addr1 = '0;
        tick(); tick();
        chk("rst_outputs", 32'({ack0, ack1, err, busy, latch_s, latch_r, latch_c}), 32'd0);
        reset = 1'b0;
        tick();

        // Simultaneous requests from reset, twice: requester 0 wins each round
        for (int r = 0; r < 2; r++) begin
            tick();
            req0 = 1'b1; op0 = 1'b1; addr0 = 2'd0;
            req1 = 1'b1; op1 = 1'b0; addr1 = 2'd2;
            push(cyc + 1, 1'b0, 1'b1, 2'd0);
            push(cyc + 1 + P + 5, 1'b1, 1'b0, 2'd2);
            wait_done();
        end

        // Single set on index 2
        issue(1'b0, 1'b1, 2'd2);
        wait_done();
        chk("q2_set", 32'(q[2]), 32'd1);

        // Requester 1 sets then clears index 1
        issue(1'b1, 1'b1, 2'd1);
        wait_done();
        chk("q1_set", 32'(q[1]), 32'd1);
        issue(1'b1, 1'b0, 2'd1);
        wait_done();
        chk("q1_clr", 32'(q[1]), 32'd0);

        // Out-of-range index: no latch line moves, err with ack
        issue(1'b0, 1'b1, 2'd3);
        wait_done();

        // Inputs changed during SETUP are ignored
        issue(1'b0, 1'b1, 2'd0);
        tick();
        addr0 = 2'd3; op0 = 1'b0;
        wait_done();
        chk("q0_set", 32'(q[0]), 32'd1);

        // Reset in the middle of the pulse abandons the command
        issue(1'b0, 1'b1, 2'd1);
        tick(); tick(); tick();
        chk("c_before_rst", 32'(latch_c), 32'b010);
        reset = 1'b1;
        #1;
        chk("rst_mid_lines", 32'({latch_s, latch_r, latch_c}), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_ack", 32'({ack1, ack0}), 32'd0);
        sb.delete();
        req0 = 1'b0;
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        // Normal latency after reset
        issue(1'b0, 1'b0, 2'd2);
        wait_done();
        chk("q2_clr", 32'(q[2]), 32'd0);

        chk("invariants", 32'(inv_bad), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
